uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
Round-robin scheduler that shares one byte-wide UART transmitter between NUM_REQ requesters, each offering a 128-bit word.
- Latches the winning word and serialises it MSB-byte-first as BYTES transmitter starts.
- Handshakes each byte against the transmitter's done pulse.
- Transmit-side counterpart to the 128-bit receive assembler; sits between the packet sources and the byte transmitter.

Parameters:
NUM_REQ, 2, number of requesters (1..8)
BYTES, 16, bytes per word; word width = 8*BYTES
GAP_CYCLES, 32, idle cycles after each word (used only with UART_TX_SCHED_GAP_EN)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  requester i has a word pending; held until its req_ready pulse
req_data  in  NUM_REQ*8*BYTES  word for requester i at slice [i*8*BYTES +: 8*BYTES]
req_ready  out  NUM_REQ  one-cycle pulse: word of requester i accepted
tx_data  out  8  byte to transmitter
tx_start  out  1  one-cycle pulse: transmit tx_data
tx_done  in  1  one-cycle pulse from transmitter: byte finished
en_tx  out  1  transmitter enable; high from word acceptance until last byte done
busy  out  1  high in any state other than IDLE
grant_id  out  clog2(NUM_REQ) (min 1)  index of requester currently being served

Behaviour:
- Reset values (async, immediate): state=IDLE, all outputs 0, rr_ptr=0, shift register 0, byte count 0.
- States: IDLE, SEND, WAIT, GAP (GAP exists only with the macro).
- IDLE, when any req_valid is high:
  - Pick the first valid index searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - At that edge: latch its word into the shift register, set grant_id, clear the count, set en_tx=1, pulse req_ready[winner] high for exactly the next cycle, go to SEND.
- SEND: drive tx_data=shreg[top byte]; tx_start is registered and high for exactly one cycle; go to WAIT.
- WAIT, on tx_done:
  - Shift the register left by 8 and increment the count.
  - If count==BYTES-1: en_tx=0, rr_ptr=grant_id+1 (wrap at NUM_REQ), go to IDLE (or GAP).
  - Otherwise go to SEND.
- tx_done seen outside WAIT is ignored.
- tx_data holds its value from SEND until the next shift.
- Latency: req_valid rises in IDLE -> req_ready and tx_start high 1 cycle later. tx_done -> next tx_start 2 cycles later.
- A requester that drops req_valid before being granted is simply skipped. req_valid changes during SEND/WAIT have no effect.
- Simultaneous requests: exactly one is granted per word. A requester's index cannot win twice in a row while another is valid.
- NUM_REQ=1: rr_ptr stays 0, back-to-back words allowed.
- Reset mid-word: the word is dropped, no partial tx_start after reset deasserts, and the requester is not re-acknowledged.

Optional Feature:
Macro UART_TX_SCHED_GAP_EN.
- Defined: after the last tx_done, enter GAP with en_tx=0 and count GAP_CYCLES cycles, then go to IDLE. Requests are not granted during GAP; busy stays high.
- Undefined: GAP state and counter are absent, and the block returns directly to IDLE.

Decomposition:
- Shared package uart_pkg: state encoding, UART_BYTE_W=8, default BYTES=16, and a clog2 helper function.
- One natural sub-module, rr_arbiter: NUM_REQ request vector plus pointer in, one-hot grant and index out. It is purely combinational; the pointer register lives in the parent.

Test Plan:
- Single word: req_valid[0]=1, word 0x00112233_44556677_8899AABB_CCDDEEFF; tx_done 10 cycles after each tx_start -> 16 tx_start pulses with tx_data 0x00,0x11,...,0xFF; req_ready[0] pulses once; en_tx falls after the 16th tx_done.
- Contention: NUM_REQ=2, both valid continuously with words A and B -> grant order 0,1,0,1; each req_ready pulses once per word.
- Stray done: tx_done pulsed in IDLE and SEND -> no shift, no count change; the sequence still yields exactly 16 bytes.
- Reset mid-word: assert reset after the 5th tx_done -> all outputs 0 immediately. With req_valid held, the next word restarts at byte 0x00 from rr_ptr=0.
- Late requester: req_valid[1] rises during word 0 -> granted in the IDLE cycle after word 0 completes; tx_start follows 1 cycle after req_ready.
- With UART_TX_SCHED_GAP_EN and GAP_CYCLES=32: back-to-back words -> exactly 32 cycles of busy=1 and en_tx=0 between the last tx_done and the next req_ready.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// =============================================================================
// Module   : uart_pkg
// Brief    : Shared constants, FSM encoding and clog2 helper for the UART TX
//            scheduler. GAP state exists only with UART_TX_SCHED_GAP_EN.
// Revision : 1.0 - initial release
// =============================================================================
package uart_pkg;

    localparam int UART_BYTE_W    = 8;
    localparam int UART_DEF_BYTES = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
`ifdef UART_TX_SCHED_GAP_EN
        ST_WAIT = 2'd2,
        ST_GAP  = 2'd3
`else
        ST_WAIT = 2'd2
`endif
    } tx_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_sched_rr_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick: first set request at or after ptr.
// Revision : 1.0 - initial release
// =============================================================================
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_grant
);

    logic [2*NUM_REQ-1:0] w_rot;
    int                   w_pos;

    // Rotating a doubled copy puts candidate ptr+k at bit k
    always_comb begin
        w_rot     = {req, req} >> ptr;
        w_pos     = 0;
        any_grant = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any_grant && w_rot[k]) begin
                any_grant = 1'b1;
                w_pos     = int'(ptr) + k;
                if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
                grant_idx = IDX_W'(w_pos);
            end
        end
        grant = any_grant ? (NUM_REQ'(1) << grant_idx) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// =============================================================================
// Module   : uart_tx_sched
// Brief    : Round-robin scheduler serialising 8*BYTES-bit words MSB byte first
//            onto one UART transmitter. Optional UART_TX_SCHED_GAP_EN inserts
//            GAP_CYCLES idle cycles after each word.
// Revision : 1.0 - initial release
// =============================================================================
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int BYTES      = UART_DEF_BYTES,
    parameter int GAP_CYCLES = 32,
    localparam int c_IDX_W   = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*UART_BYTE_W*BYTES-1:0] req_data,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [UART_BYTE_W-1:0]           tx_data,
    output logic                             tx_start,
    input  logic                             tx_done,
    output logic                             en_tx,
    output logic                             busy,
    output logic [c_IDX_W-1:0]               grant_id
);

    localparam int c_WORD_W = UART_BYTE_W * BYTES;
    localparam int c_CNT_W  = (BYTES > 1) ? clog2(BYTES) : 1;

    tx_state_t            r_state, w_state_nxt;
    logic [c_WORD_W-1:0]  r_shreg, w_shreg_nxt, w_word;
    logic [c_CNT_W-1:0]   r_count, w_count_nxt;
    logic [c_IDX_W-1:0]   r_grant_id, w_grant_nxt;
    logic [c_IDX_W-1:0]   r_rr_ptr, w_rr_nxt;
    logic                 r_en_tx, w_en_nxt;
    logic [NUM_REQ-1:0]   r_req_ready, w_ready_nxt;
    logic                 r_tx_start, w_start_nxt;
    logic [NUM_REQ-1:0]   w_arb_grant;
    logic [c_IDX_W-1:0]   w_arb_idx;
    logic                 w_arb_any;

`ifdef UART_TX_SCHED_GAP_EN
    localparam int c_GAP_W = (GAP_CYCLES > 1) ? clog2(GAP_CYCLES) : 1;
    logic [c_GAP_W-1:0]   r_gap_cnt, w_gap_nxt;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (r_rr_ptr),
        .grant     (w_arb_grant),
        .grant_idx (w_arb_idx),
        .any_grant (w_arb_any)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_count_nxt = r_count;
        w_grant_nxt = r_grant_id;
        w_rr_nxt    = r_rr_ptr;
        w_en_nxt    = r_en_tx;
        w_ready_nxt = '0;
        w_start_nxt = 1'b0;
        w_word      = '0;
`ifdef UART_TX_SCHED_GAP_EN
        w_gap_nxt   = r_gap_cnt;
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_arb_grant[i]) w_word = req_data[i*c_WORD_W +: c_WORD_W];
        end

        case (r_state)
            ST_IDLE: begin
                if (w_arb_any) begin
                    w_shreg_nxt = w_word;
                    w_grant_nxt = w_arb_idx;
                    w_count_nxt = '0;
                    w_en_nxt    = 1'b1;
                    w_ready_nxt = w_arb_grant;
                    w_start_nxt = 1'b1;
                    w_state_nxt = ST_SEND;
                end
            end
            // First byte arrives with tx_start already issued; later bytes
            // issue it here, giving the two-cycle done-to-start spacing
            ST_SEND: begin
                if (r_tx_start) w_state_nxt = ST_WAIT;
                else            w_start_nxt = 1'b1;
            end
            ST_WAIT: begin
                if (tx_done) begin
                    w_shreg_nxt = r_shreg << UART_BYTE_W;
                    w_count_nxt = r_count + 1'b1;
                    if (r_count == c_CNT_W'(BYTES - 1)) begin
                        w_en_nxt = 1'b0;
                        w_rr_nxt = (r_grant_id == c_IDX_W'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;
`ifdef UART_TX_SCHED_GAP_EN
                        w_gap_nxt   = '0;
                        w_state_nxt = ST_GAP;
`else
                        w_state_nxt = ST_IDLE;
`endif
                    end else begin
                        w_state_nxt = ST_SEND;
                    end
                end
            end
`ifdef UART_TX_SCHED_GAP_EN
            ST_GAP: begin
                if (r_gap_cnt == c_GAP_W'(GAP_CYCLES - 1)) w_state_nxt = ST_IDLE;
                else                                       w_gap_nxt   = r_gap_cnt + 1'b1;
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_shreg     <= '0;
            r_count     <= '0;
            r_grant_id  <= '0;
            r_rr_ptr    <= '0;
            r_en_tx     <= 1'b0;
            r_req_ready <= '0;
            r_tx_start  <= 1'b0;
`ifdef UART_TX_SCHED_GAP_EN
            r_gap_cnt   <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_shreg     <= w_shreg_nxt;
            r_count     <= w_count_nxt;
            r_grant_id  <= w_grant_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_en_tx     <= w_en_nxt;
            r_req_ready <= w_ready_nxt;
            r_tx_start  <= w_start_nxt;
`ifdef UART_TX_SCHED_GAP_EN
            r_gap_cnt   <= w_gap_nxt;
`endif
        end
    end

    assign req_ready = r_req_ready;
    assign tx_data   = r_shreg[c_WORD_W-1 -: UART_BYTE_W];
    assign tx_start  = r_tx_start;
    assign en_tx     = r_en_tx;
    assign busy      = (r_state != ST_IDLE);
    assign grant_id  = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// =============================================================================
// Module   : tb_uart_tx_sched
// Brief    : Self-checking bench for uart_tx_sched (vector table, hand-written
//            corner sequences, randomized words against a round-robin model).
// Revision : 1.0 - initial release
// =============================================================================
module tb_uart_tx_sched;

    localparam int NUM_REQ    = 2;
    localparam int BYTES      = 16;
    localparam int GAP_CYCLES = 32;
    localparam int WW         = 8 * BYTES;
`ifdef UART_TX_SCHED_GAP_EN
    localparam int       CHAIN_LAT = GAP_CYCLES + 1;
    localparam bit [0:0] GAP_ON    = 1'b1;
`else
    localparam int       CHAIN_LAT = 1;
    localparam bit [0:0] GAP_ON    = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*WW-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic [7:0]            tx_data;
    logic                  tx_start;
    logic                  tx_done;
    logic                  en_tx;
    logic                  busy;
    logic [0:0]            grant_id;

    logic [WW-1:0] words [NUM_REQ];
    int            n_checks;
    int            n_fail;
    int            model_ptr;

    assign req_data = {words[1], words[0]};

    always #5 clk = ~clk;

    uart_tx_sched #(
        .NUM_REQ    (NUM_REQ),
        .BYTES      (BYTES),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_done   (tx_done),
        .en_tx     (en_tx),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    typedef struct {
        logic [1:0] valid;
        int         exp_grant;
        int         dly;
        bit         stray;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference round robin: first valid index scanning from the pointer
    function automatic int model_pick(input logic [1:0] vm);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (vm[(model_ptr + k) % NUM_REQ]) return (model_ptr + k) % NUM_REQ;
        end
        return 0;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_tx_start"}, tx_start, 0);
        check({tag, "_tx_data"}, tx_data, 0);
        check({tag, "_en_tx"}, en_tx, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_grant_id"}, grant_id, 0);
    endtask

    task automatic settle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("settle_busy", busy, 0);
        @(negedge clk);
        check("idle_no_start", tx_start, 0);
    endtask

    // Drives one word through the DUT acting as the transmitter; returns on the
    // negedge after the last (or abort_after-th) tx_done has been sampled.
    task automatic run_word(input logic [1:0] vmask, input int exp_idx, input int exp_lat,
                            input int dly, input bit stray, input bit hold,
                            input int abort_after, input logic [1:0] late_mask);
        int          lat;
        logic [WW-1:0] w;
        logic [7:0]  eb;
        req_valid = vmask;
        w = words[exp_idx];
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (req_ready == 0 && lat < exp_lat + 40);
        check("ready_latency", lat, exp_lat);
        check("req_ready_onehot", req_ready, 2'b01 << exp_idx);
        check("grant_id", grant_id, exp_idx);
        check("start_with_ready", tx_start, 1);
        check("en_tx_on", en_tx, 1);
        if (!hold) req_valid = '0;
        for (int k = 0; k < BYTES; k++) begin
            eb = w[WW-1-8*k -: 8];
            if (k > 0) begin
                lat = 0;
                do begin
                    @(negedge clk);
                    lat++;
                end while (!tx_start && lat < 40);
                check("done_to_start", lat, 1);
            end
            check("tx_data", tx_data, eb);
            if (stray) tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
            check("start_pulse_width", tx_start, 0);
            if (k == 0) check("ready_pulse_width", req_ready, 0);
            repeat (dly - 1) @(negedge clk);
            check("data_hold", tx_data, eb);
            check("en_tx_mid", en_tx, 1);
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
            if (k + 1 == 3) req_valid = req_valid | late_mask;
            if (k + 1 == abort_after) return;
            if (k == BYTES - 1) begin
                check("en_tx_off", en_tx, 0);
                check("end_busy", busy, GAP_ON);
                model_ptr = (exp_idx + 1) % NUM_REQ;
            end else begin
                check("no_early_start", tx_start, 0);
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cnt;
        int         n;
        int         e;
        logic [1:0] vm;
        n_checks  = 0;
        n_fail    = 0;
        model_ptr = 0;
        reset     = 1'b1;
        req_valid = '0;
        tx_done   = 1'b0;
        words[0]  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        words[1]  = 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F;

        tbl[0] = '{valid: 2'b01, exp_grant: 0, dly: 10, stray: 1'b0};
        tbl[1] = '{valid: 2'b01, exp_grant: 0, dly: 3,  stray: 1'b0};
        tbl[2] = '{valid: 2'b11, exp_grant: 1, dly: 1,  stray: 1'b1};
        tbl[3] = '{valid: 2'b11, exp_grant: 0, dly: 2,  stray: 1'b0};
        tbl[4] = '{valid: 2'b10, exp_grant: 1, dly: 1,  stray: 1'b0};
        tbl[5] = '{valid: 2'b11, exp_grant: 0, dly: 4,  stray: 1'b1};

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Stray done in IDLE must not start or disturb anything
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        @(negedge clk);
        check("stray_idle_busy", busy, 0);
        check("stray_idle_start", tx_start, 0);

        for (int i = 0; i < 6; i++) begin
            settle();
            run_word(tbl[i].valid, tbl[i].exp_grant, 1, tbl[i].dly, tbl[i].stray, 1'b0, 0, 2'b00);
        end

        // Late requester arrives mid-word and is served right after
        settle();
        run_word(2'b01, 0, 1, 2, 1'b0, 1'b0, 0, 2'b10);
        run_word(2'b10, 1, CHAIN_LAT, 2, 1'b0, 1'b0, 0, 2'b00);

        // Continuous contention alternates 0,1,0,1
        settle();
        run_word(2'b11, 0, 1,         1, 1'b0, 1'b1, 0, 2'b00);
        run_word(2'b11, 1, CHAIN_LAT, 1, 1'b0, 1'b1, 0, 2'b00);
        run_word(2'b11, 0, CHAIN_LAT, 1, 1'b0, 1'b1, 0, 2'b00);
        run_word(2'b11, 1, CHAIN_LAT, 1, 1'b0, 1'b0, 0, 2'b00);

        // Reset mid-word: pointer is 1 beforehand, so grant 0 after proves rr_ptr cleared
        settle();
        run_word(2'b01, 0, 1, 1, 1'b0, 1'b0, 0, 2'b00);
        settle();
        run_word(2'b10, 1, 1, 2, 1'b0, 1'b0, 5, 2'b00);
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        model_ptr = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_reset_start", tx_start, 0);
            check("post_reset_busy", busy, 0);
        end
        run_word(2'b11, 0, 1, 1, 1'b0, 1'b0, 0, 2'b00);

`ifdef UART_TX_SCHED_GAP_EN
        // Gap length between last done and the next grant
        settle();
        run_word(2'b01, model_pick(2'b01), 1, 1, 1'b0, 1'b1, 0, 2'b00);
        cnt = 0;
        n = 0;
        while (req_ready == 0 && n < 200) begin
            if (busy && !en_tx) cnt++;
            @(negedge clk);
            n++;
        end
        check("gap_cycles", cnt, GAP_CYCLES);
        req_valid = '0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_ptr = 0;
`endif

        for (int it = 0; it < 12; it++) begin
            settle();
            vm = 2'($urandom_range(1, 3));
            words[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
            words[1] = {$urandom(), $urandom(), $urandom(), $urandom()};
            e = model_pick(vm);
            run_word(vm, e, 1, int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), 1'b0, 0, 2'b00);
        end
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
